// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one 64-bit single-port memory between the fetch port and the
// load/store port, with bounded data streaks, memory timeout and registered acks.
module mem_port_arbiter #(
  parameter int ADDR_BITS    = 6,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic [63:0]          d_rdata,
  output logic                 d_ack,
  output logic                 err,
  output logic                 stall,
  output logic                 m_req,
  output logic                 m_we,
  output logic [ADDR_BITS-4:0] m_addr,
  output logic [63:0]          m_wdata,
  input  logic [63:0]          m_rdata,
  input  logic                 m_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_I = 2'd1;
  localparam logic [1:0] S_GNT_D = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]           r_state;
  logic [3:0]           r_streak;
  logic [7:0]           r_timeout;
  logic                 r_gntD;
  logic                 r_iHalf;
  logic                 r_timedOut;
  logic [63:0]          r_word;
  logic                 r_mReq;
  logic                 r_mWe;
  logic [ADDR_BITS-4:0] r_mAddr;
  logic [63:0]          r_mWdata;
  logic                 r_iAck;
  logic                 r_dAck;
  logic                 r_err;
  logic [31:0]          r_iRdata;
  logic [63:0]          r_dRdata;

  logic w_ackBusy;
  logic w_pickD;
  logic w_unusedBits;

  // The ack cycle still shows the old request, so arbitration waits one cycle.
  assign w_ackBusy    = r_iAck | r_dAck;
  assign w_pickD      = d_req & (~i_req | (r_streak < 4'(MAX_D_STREAK)));
  assign w_unusedBits = &{1'b0, i_addr[1:0], d_addr[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_streak   <= '0;
      r_timeout  <= '0;
      r_gntD     <= 1'b0;
      r_iHalf    <= 1'b0;
      r_timedOut <= 1'b0;
      r_word     <= '0;
      r_mReq     <= 1'b0;
      r_mWe      <= 1'b0;
      r_mAddr    <= '0;
      r_mWdata   <= '0;
      r_iAck     <= 1'b0;
      r_dAck     <= 1'b0;
      r_err      <= 1'b0;
      r_iRdata   <= '0;
      r_dRdata   <= '0;
    end else begin
      r_iAck   <= 1'b0;
      r_dAck   <= 1'b0;
      r_err    <= 1'b0;
      r_iRdata <= '0;
      r_dRdata <= '0;
      case (r_state)
        S_IDLE: begin
          r_timeout <= '0;
          if (!w_ackBusy) begin
            if (w_pickD) begin
              r_state  <= S_GNT_D;
              r_gntD   <= 1'b1;
              r_mReq   <= 1'b1;
              r_mWe    <= d_we;
              r_mAddr  <= d_addr[ADDR_BITS-1:3];
              r_mWdata <= d_wdata;
              r_streak <= i_req ? r_streak + 4'd1 : 4'd0;
            end else if (i_req) begin
              r_state  <= S_GNT_I;
              r_gntD   <= 1'b0;
              r_iHalf  <= i_addr[2];
              r_mReq   <= 1'b1;
              r_mWe    <= 1'b0;
              r_mAddr  <= i_addr[ADDR_BITS-1:3];
              r_mWdata <= '0;
              r_streak <= '0;
            end else begin
              r_streak <= '0;
            end
          end
        end
        S_GNT_I, S_GNT_D: begin
          // m_ready is checked first so a late response beats the timeout.
          if (m_ready) begin
            r_word     <= m_rdata;
            r_timedOut <= 1'b0;
            r_mReq     <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_timeout == 8'(TIMEOUT - 1)) begin
            r_word     <= '0;
            r_timedOut <= 1'b1;
            r_mReq     <= 1'b0;
            r_state    <= S_RESP;
          end else begin
            r_timeout <= r_timeout + 8'd1;
          end
        end
        default: begin
          r_err   <= r_timedOut;
          r_state <= S_IDLE;
          if (r_gntD) begin
            r_dAck   <= 1'b1;
            r_dRdata <= r_mWe ? 64'd0 : r_word;
          end else begin
            r_iAck   <= 1'b1;
            r_iRdata <= r_iHalf ? r_word[63:32] : r_word[31:0];
          end
        end
      endcase
    end
  end

  assign i_ack   = r_iAck;
  assign d_ack   = r_dAck;
  assign err     = r_err;
  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;
  assign m_req   = r_mReq;
  assign m_we    = r_mWe;
  assign m_addr  = r_mAddr;
  assign m_wdata = r_mWdata;
  assign stall   = (i_req & ~r_iAck) | (d_req & ~r_dAck);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, multi-cycle corner sequences and
// randomized single transactions against a transaction-level memory model.
module tb_mem_port_arbiter;

  localparam int MAXD = 4;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [5:0]  i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [5:0]  d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        stall;
  logic        m_req;
  logic        m_we;
  logic [2:0]  m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem [8];
  logic [63:0] refMem [8];
  int memDelay = 0;
  int gntCnt = 0;

  mem_port_arbiter #(.ADDR_BITS(6), .MAX_D_STREAK(MAXD), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Memory stub: answers on GNT cycle memDelay+1, otherwise shows junk data.
  always begin
    @(posedge clk);
    #1;
    if (m_req) begin
      gntCnt = gntCnt + 1;
      if (gntCnt == memDelay + 1) begin
        m_ready = 1'b1;
        m_rdata = mem[m_addr];
        if (m_we) mem[m_addr] = m_wdata;
      end else begin
        m_ready = 1'b0;
        m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end else begin
      gntCnt  = 0;
      m_ready = 1'b0;
      m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  typedef struct {
    bit          isData;
    bit          we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] expRdata;
    bit          expErr;
    int          expCyc;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request at +2 after an edge and follows it to its ack.
  task automatic applyStimulus(input bit isData, input bit we, input logic [5:0] addr,
                               input logic [63:0] wdata, input int delay,
                               output int ackCyc, output logic [63:0] rdata, output logic errOut,
                               output logic [2:0] seenAddr, output logic seenWe,
                               output logic [63:0] seenWdata, output bit stallOk,
                               output bit wrongAck);
    bit gotAddr = 0;
    memDelay = delay;
    ackCyc = -1; rdata = '0; errOut = 1'b0; stallOk = 1; wrongAck = 0;
    seenAddr = '0; seenWe = 1'b0; seenWdata = '0;
    if (isData) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    #1;
    if (!stall) stallOk = 0;
    for (int c = 1; c <= 40 && ackCyc < 0; c++) begin
      @(posedge clk);
      #2;
      if (m_req && !gotAddr) begin
        gotAddr = 1; seenAddr = m_addr; seenWe = m_we; seenWdata = m_wdata;
      end
      if (isData ? d_ack : i_ack) begin
        ackCyc = c;
        rdata  = isData ? d_rdata : {32'd0, i_rdata};
        errOut = err;
        if (stall) stallOk = 0;
        if (isData ? i_ack : d_ack) wrongAck = 1;
      end else begin
        if (!stall) stallOk = 0;
        if (i_ack || d_ack || err) wrongAck = 1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #2;
  endtask

  int          ackCyc;
  logic [63:0] rdata;
  logic        errOut;
  logic [2:0]  seenAddr;
  logic        seenWe;
  logic [63:0] seenWdata;
  bit          stallOk;
  bit          wrongAck;

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = {32'hC0DE_0000 + 32'(k), 32'hF00D_0000 + 32'(k)};
    mem[1] = 64'hAAAA_BBBB_1111_2222;
    mem[7] = 64'h0123_4567_89AB_CDEF;

    vecs[0] = '{0, 0, 6'h0C, 64'h0,  0,   64'hAAAABBBB,           0, 3};
    vecs[1] = '{0, 0, 6'h08, 64'h0,  0,   64'h11112222,           0, 3};
    vecs[2] = '{1, 1, 6'h10, 64'h55, 0,   64'h0,                  0, 3};
    vecs[3] = '{1, 0, 6'h10, 64'h0,  2,   64'h55,                 0, 5};
    vecs[4] = '{0, 0, 6'h10, 64'h0,  15,  64'h55,                 0, 18};
    vecs[5] = '{1, 0, 6'h08, 64'h0,  255, 64'h0,                  1, 18};
    vecs[6] = '{1, 0, 6'h38, 64'h0,  1,   64'h0123456789ABCDEF,   0, 4};
    vecs[7] = '{0, 0, 6'h3C, 64'h0,  1,   64'h01234567,           0, 4};
    vecs[8] = '{1, 1, 6'h18, 64'h77, 255, 64'h0,                  1, 18};
    vecs[9] = '{1, 0, 6'h18, 64'h0,  0,   64'hC0DE0003F00D0003,   0, 3};

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset outputs",
                {63'd0, i_ack, d_ack, err, stall, m_req, m_we, m_addr},
                {63'd0, 9'd0});
    checkOutput("reset data", {i_rdata, d_rdata, m_wdata} == '0 ? 64'd1 : 64'd0, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].isData, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay,
                    ackCyc, rdata, errOut, seenAddr, seenWe, seenWdata, stallOk, wrongAck);
      checkOutput($sformatf("vec%0d ack cycle", v), 64'(ackCyc), 64'(vecs[v].expCyc));
      checkOutput($sformatf("vec%0d rdata", v), rdata, vecs[v].expRdata);
      checkOutput($sformatf("vec%0d err", v), 64'(errOut), 64'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d m_addr", v), 64'(seenAddr), 64'(vecs[v].addr[5:3]));
      checkOutput($sformatf("vec%0d m_we", v), 64'(seenWe), 64'(vecs[v].we));
      checkOutput($sformatf("vec%0d stall", v), 64'(stallOk), 64'd1);
      checkOutput($sformatf("vec%0d stray ack", v), 64'(wrongAck), 64'd0);
      if (vecs[v].we) checkOutput($sformatf("vec%0d m_wdata", v), seenWdata, vecs[v].wdata);
    end

    // Both ports at once: the store goes first, then the fetch.
    begin
      int dCyc = -1;
      int iCyc = -1;
      logic [63:0] dData = '1;
      logic [31:0] iData = '1;
      logic sWe = 1'b0;
      logic [63:0] sWdata = '0;
      memDelay = 0;
      i_req = 1'b1; i_addr = 6'h0C;
      d_req = 1'b1; d_we = 1'b1; d_addr = 6'h10; d_wdata = 64'h55;
      for (int c = 1; c <= 30 && iCyc < 0; c++) begin
        @(posedge clk);
        #2;
        if (m_req && dCyc < 0 && c == 1) begin sWe = m_we; sWdata = m_wdata; end
        if (d_ack) begin dCyc = c; dData = d_rdata; d_req = 1'b0; end
        if (i_ack) begin iCyc = c; iData = i_rdata; i_req = 1'b0; end
      end
      i_req = 1'b0; d_req = 1'b0;
      checkOutput("both: d_ack cycle", 64'(dCyc), 64'd3);
      checkOutput("both: i_ack cycle", 64'(iCyc), 64'd7);
      checkOutput("both: m_we", 64'(sWe), 64'd1);
      checkOutput("both: m_wdata", sWdata, 64'h55);
      checkOutput("both: d_rdata", dData, 64'h0);
      checkOutput("both: i_rdata", 64'(iData), 64'hAAAABBBB);
      @(posedge clk);
      #2;
    end

    // Both held high: the fetch may wait behind at most MAXD data grants.
    begin
      bit order [10];
      bit expOrder [10];
      int n = 0;
      int streak = 0;
      memDelay = 0;
      i_req = 1'b1; i_addr = 6'h08;
      d_req = 1'b1; d_we = 1'b0; d_addr = 6'h38;
      for (int c = 0; c < 200 && n < 10; c++) begin
        @(posedge clk);
        #2;
        if (d_ack) begin order[n] = 1; n++; end
        else if (i_ack) begin order[n] = 0; n++; end
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (streak < MAXD) begin expOrder[k] = 1; streak++; end
        else begin expOrder[k] = 0; streak = 0; end
      end
      checkOutput("streak: grant count", 64'(n), 64'd10);
      for (int k = 0; k < 10; k++)
        checkOutput($sformatf("streak: grant %0d is data", k), 64'(order[k]), 64'(expOrder[k]));
      repeat (2) @(posedge clk);
      #2;
    end

    // Reset while a load is waiting on memory.
    begin
      bit ackSeen = 0;
      memDelay = 255;
      d_req = 1'b1; d_we = 1'b0; d_addr = 6'h08;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst: m_req before reset", 64'(m_req), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("rst: m_req after reset", 64'(m_req), 64'd0);
      rst_n = 1'b1; d_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #2;
        if (d_ack || i_ack || err || m_req) ackSeen = 1;
      end
      checkOutput("rst: no ack afterwards", 64'(ackSeen), 64'd0);
      applyStimulus(0, 0, 6'h0C, 64'h0, 0, ackCyc, rdata, errOut, seenAddr, seenWe,
                    seenWdata, stallOk, wrongAck);
      checkOutput("rst: recovery ack cycle", 64'(ackCyc), 64'd3);
      checkOutput("rst: recovery rdata", rdata, 64'hAAAABBBB);
    end

    // Random single transactions against a transaction-level model.
    for (int k = 0; k < 8; k++) refMem[k] = mem[k];
    for (int t = 0; t < 40; t++) begin
      bit          isData = 1'($urandom_range(0, 1));
      bit          we = isData ? 1'($urandom_range(0, 1)) : 1'b0;
      logic [5:0]  addr = 6'($urandom_range(0, 63)) & (isData ? 6'h38 : 6'h3C);
      logic [63:0] wdata = {$urandom, $urandom};
      int          delay = int'($urandom_range(0, 20));
      bit          timedOut = (delay + 1 > TOUT);
      int          expCyc = (timedOut ? TOUT : delay + 1) + 2;
      logic [63:0] word = timedOut ? 64'd0 : refMem[addr[5:3]];
      logic [63:0] expRdata;
      if (!isData) expRdata = addr[2] ? {32'd0, word[63:32]} : {32'd0, word[31:0]};
      else expRdata = we ? 64'd0 : word;
      if (isData && we && !timedOut) refMem[addr[5:3]] = wdata;
      applyStimulus(isData, we, addr, wdata, delay, ackCyc, rdata, errOut, seenAddr, seenWe,
                    seenWdata, stallOk, wrongAck);
      checkOutput($sformatf("rand%0d ack cycle", t), 64'(ackCyc), 64'(expCyc));
      checkOutput($sformatf("rand%0d rdata", t), rdata, expRdata);
      checkOutput($sformatf("rand%0d err", t), 64'(errOut), 64'(timedOut));
      checkOutput($sformatf("rand%0d m_addr", t), 64'(seenAddr), 64'(addr[5:3]));
      if (we) checkOutput($sformatf("rand%0d m_wdata", t), seenWdata, wdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
